// File: rtl/uart_pkg.sv
// Constants shared by the baud generator and the UART transmitter/receiver.
// Divisor width, oversampling range and power-up divisor live here.
package uart_pkg;

    localparam int UART_DIV_WIDTH   = 16;
    localparam int UART_OVS         = 16;
    localparam int UART_OVS_MIN     = 4;
    localparam int UART_OVS_MAX     = 64;
    localparam int UART_DEFAULT_DIV = 163;

    function automatic int phase_width(input int ovs);
        return (ovs < 2) ? 1 : $clog2(ovs);
    endfunction

    function automatic bit ovs_legal(input int ovs);
        return (ovs >= UART_OVS_MIN) && (ovs <= UART_OVS_MAX) && ((ovs % 2) == 0);
    endfunction

endpackage

// File: rtl/baud_phase_counter.sv
// Modulo-OVS phase counter advancing on the oversample strobe, with a
// synchronous clear that overrides the advance and suppresses the strobe.
module baud_phase_counter
    import uart_pkg::*;
#(
    parameter int OVS  = UART_OVS,
    parameter int TERM = OVS - 1
) (
    input  logic clk_in,
    input  logic reset,
    input  logic i_advance,
    input  logic i_clear,
    output logic o_strobe
);

    localparam int PW = phase_width(OVS);

    logic [PW-1:0] r_phase;
    logic          w_at_last;

    assign w_at_last = (r_phase == PW'(OVS - 1));

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_phase <= '0;
        end else if (i_clear) begin
            r_phase <= '0;
        end else if (i_advance) begin
            r_phase <= w_at_last ? '0 : r_phase + PW'(1);
        end
    end

    // A clear landing on an advance cycle wins: no strobe from the old phase.
    assign o_strobe = i_advance & ~i_clear & (r_phase == PW'(TERM));

endmodule

// File: rtl/baud_generator.sv
// Programmable baud generator: divisor prescaler producing the oversample
// strobe, plus tx bit-rate and rx bit-centre phase counters.
module baud_generator
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH   = UART_DIV_WIDTH,
    parameter int OVS         = UART_OVS,
    parameter int DEFAULT_DIV = UART_DEFAULT_DIV
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 div_wr,
    input  logic [DIV_WIDTH-1:0] div_in,
    input  logic                 rx_sync,
    output logic                 os_tick,
    output logic                 tx_tick,
    output logic                 rx_sample,
    output logic [DIV_WIDTH-1:0] div_cur
);

    localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DEFAULT_DIV);

    logic [DIV_WIDTH-1:0] r_presc;
    logic [DIV_WIDTH-1:0] r_div_cur;
    logic [DIV_WIDTH-1:0] r_div_pend;
    logic                 r_pend_valid;

    logic [DIV_WIDTH-1:0] w_div_eff;
    logic [DIV_WIDTH-1:0] w_term;
    logic                 w_wrap;
    logic                 w_apply;
    logic [1:0]           w_clear;
    logic [1:0]           w_strobe;

    assign w_div_eff = (r_div_cur > DIV_ONE) ? r_div_cur : DIV_ONE;
    assign w_term    = w_div_eff - DIV_ONE;
    // ">=" lets a divisor shrunk while disabled wrap on the next enabled cycle.
    assign w_wrap    = enable & ~reset & (r_presc >= w_term);
    assign w_apply   = r_pend_valid & (w_wrap | ~enable);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_presc      <= '0;
            r_div_cur    <= DIV_RST;
            r_div_pend   <= DIV_RST;
            r_pend_valid <= 1'b0;
        end else begin
            if (w_wrap) begin
                r_presc <= '0;
            end else if (enable) begin
                r_presc <= r_presc + DIV_ONE;
            end

            if (w_apply) begin
                r_div_cur <= r_div_pend;
            end

            // A write coincident with a wrap lands in pending for the next wrap.
            if (div_wr) begin
                r_div_pend   <= div_in;
                r_pend_valid <= 1'b1;
            end else if (w_apply) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    // Index 0 is the tx bit-rate counter, index 1 the rx bit-centre counter.
    assign w_clear = {rx_sync, 1'b0};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_phase
            baud_phase_counter #(
                .OVS  (OVS),
                .TERM ((gi == 0) ? (OVS - 1) : (OVS / 2 - 1))
            ) u_phase (
                .clk_in    (clk_in),
                .reset     (reset),
                .i_advance (w_wrap),
                .i_clear   (w_clear[gi]),
                .o_strobe  (w_strobe[gi])
            );
        end
    endgenerate

    assign os_tick   = w_wrap;
    assign tx_tick   = w_strobe[0];
    assign rx_sample = w_strobe[1];
    assign div_cur   = r_div_cur;

endmodule
